// File: rtl/uart_sync_fifo.sv
// Parametrised synchronous FIFO for the UART TX/RX paths: full-depth storage, occupancy count,
// threshold flags, sticky error flags, synchronous flush and optional first-word-fall-through reads.
module uart_sync_fifo #(
    parameter int DWIDTH   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     writeEn,
    input  logic [DWIDTH-1:0]        dataIn,
    input  logic                     readEn,
    output logic [DWIDTH-1:0]        dataOut,
    output logic                     rdValid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     EMPTY,
    output logic                     FULL,
    output logic                     ALMOST_EMPTY,
    output logic                     ALMOST_FULL,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DWIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wptr_r;
    logic [AW-1:0]     rptr_r;
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     count_nxt_s;
    logic              overflow_r;
    logic              underflow_r;
    logic              clear_s;
    logic              empty_s;
    logic              full_s;
    logic              wr_ok_s;
    logic              rd_ok_s;

    // Flags decode the registered count, so they trail the causing edge by one cycle
    assign empty_s = (count_r == {CW{1'b0}});
    assign full_s  = (count_r == CW'(DEPTH));
    assign clear_s = reset | flush;
    assign wr_ok_s = writeEn & ~full_s & ~clear_s;
    assign rd_ok_s = readEn & ~empty_s & ~clear_s;

    // Occupancy update: a simultaneous push and pop leaves the count unchanged
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_ok_s, rd_ok_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, count and sticky error flags; reset outranks flush, both discard pending traffic
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wptr_r      <= {AW{1'b0}};
            rptr_r      <= {AW{1'b0}};
            count_r     <= {CW{1'b0}};
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            if (wr_ok_s) begin
                wptr_r <= wptr_r + AW'(1);
            end
            if (rd_ok_s) begin
                rptr_r <= rptr_r + AW'(1);
            end
            if (writeEn && full_s) begin
                overflow_r <= 1'b1;
            end
            if (readEn && empty_s) begin
                underflow_r <= 1'b1;
            end
        end
    end

    // Storage array; contents survive reset and flush
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wptr_r] <= dataIn;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented directly; readEn only acknowledges it
            always_comb begin
                dataOut = {DWIDTH{1'b0}};
                if (empty_s) begin
                    dataOut = {DWIDTH{1'b0}};
                end else begin
                    dataOut = mem_r[rptr_r];
                end
            end
            assign rdValid = ~empty_s;
        end else begin : g_std
            logic [DWIDTH-1:0] dout_r;
            logic              rdvalid_r;

            // Registered read port with a one-cycle valid pulse per accepted pop
            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    dout_r    <= {DWIDTH{1'b0}};
                    rdvalid_r <= 1'b0;
                end else begin
                    rdvalid_r <= rd_ok_s;
                    if (rd_ok_s) begin
                        dout_r <= mem_r[rptr_r];
                    end
                end
            end
            assign dataOut = dout_r;
            assign rdValid = rdvalid_r;
        end
    endgenerate

    assign count        = count_r;
    assign EMPTY        = empty_s;
    assign FULL         = full_s;
    assign ALMOST_EMPTY = (count_r <= CW'(AE_LEVEL));
    assign ALMOST_FULL  = (count_r >= CW'(AF_LEVEL));
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Directed bench for uart_sync_fifo: a standard-mode instance driven from a vector table and
// hand sequences, plus a FWFT instance sharing the same inputs.
module tb_uart_sync_fifo;

    logic       clk = 1'b0;
    logic       reset, flush, writeEn, readEn;
    logic [7:0] dataIn;

    logic [7:0] dout_s, dout_f;
    logic       rv_s, rv_f;
    logic [4:0] cnt_s, cnt_f;
    logic       e_s, f_s, ae_s, af_s, ov_s, un_s;
    logic       e_f, f_f, ae_f, af_f, ov_f, un_f;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_sync_fifo #(.DWIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(1), .FWFT(0)) dut (
        .clk(clk), .reset(reset), .flush(flush), .writeEn(writeEn), .dataIn(dataIn),
        .readEn(readEn), .dataOut(dout_s), .rdValid(rv_s), .count(cnt_s), .EMPTY(e_s),
        .FULL(f_s), .ALMOST_EMPTY(ae_s), .ALMOST_FULL(af_s), .overflow(ov_s), .underflow(un_s)
    );

    uart_sync_fifo #(.DWIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(1), .FWFT(1)) dut_f (
        .clk(clk), .reset(reset), .flush(flush), .writeEn(writeEn), .dataIn(dataIn),
        .readEn(readEn), .dataOut(dout_f), .rdValid(rv_f), .count(cnt_f), .EMPTY(e_f),
        .FULL(f_f), .ALMOST_EMPTY(ae_f), .ALMOST_FULL(af_f), .overflow(ov_f), .underflow(un_f)
    );

    typedef struct {
        logic       rst, fl, we, re;
        logic [7:0] din;
        logic [4:0] cnt;
        logic       ov, un, rv;
        logic [7:0] dout;
    } vec_t;

    vec_t tbl [40];
    int   n_vec;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic fl, input logic we, input logic re,
                        input logic [7:0] d);
        reset = r; flush = fl; writeEn = we; readEn = re; dataIn = d;
        @(posedge clk);
        #1;
    endtask

    // Standard-mode check; level flags follow from the expected count (AF=14, AE=1, DEPTH=16)
    task automatic exp_std(input string nm, input logic [4:0] c, input logic ov, input logic un,
                           input logic rv, input logic [7:0] d);
        chk({nm, ".count"}, {3'b000, cnt_s}, {3'b000, c});
        chk({nm, ".EMPTY"}, {7'd0, e_s}, {7'd0, c == 5'd0});
        chk({nm, ".FULL"}, {7'd0, f_s}, {7'd0, c == 5'd16});
        chk({nm, ".AE"}, {7'd0, ae_s}, {7'd0, c <= 5'd1});
        chk({nm, ".AF"}, {7'd0, af_s}, {7'd0, c >= 5'd14});
        chk({nm, ".overflow"}, {7'd0, ov_s}, {7'd0, ov});
        chk({nm, ".underflow"}, {7'd0, un_s}, {7'd0, un});
        chk({nm, ".rdValid"}, {7'd0, rv_s}, {7'd0, rv});
        chk({nm, ".dataOut"}, dout_s, d);
    endtask

    task automatic exp_fw(input string nm, input logic [4:0] c, input logic rv,
                          input logic [7:0] d);
        chk({nm, ".count"}, {3'b000, cnt_f}, {3'b000, c});
        chk({nm, ".EMPTY"}, {7'd0, e_f}, {7'd0, c == 5'd0});
        chk({nm, ".rdValid"}, {7'd0, rv_f}, {7'd0, rv});
        chk({nm, ".dataOut"}, dout_f, d);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; writeEn = 1'b0; readEn = 1'b0; dataIn = 8'h00;

        // Vector table: reset, fill 0x00..0x0F, drain, empty-read, write+read on empty, flush
        n_vec = 0;
        tbl[n_vec++] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00};
        for (int i = 0; i < 16; i++)
            tbl[n_vec++] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'(i), 5'(i + 1), 1'b0, 1'b0, 1'b0, 8'h00};
        for (int k = 0; k < 16; k++)
            tbl[n_vec++] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 5'(15 - k), 1'b0, 1'b0, 1'b1, 8'(k)};
        tbl[n_vec++] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0, 8'h0F};
        tbl[n_vec++] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 8'h0F};
        tbl[n_vec++] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h77, 5'd1, 1'b0, 1'b1, 1'b0, 8'h0F};
        tbl[n_vec++] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h99, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00};

        for (int i = 0; i < n_vec; i++) begin
            step(tbl[i].rst, tbl[i].fl, tbl[i].we, tbl[i].re, tbl[i].din);
            exp_std($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].ov, tbl[i].un, tbl[i].rv,
                    tbl[i].dout);
        end

        // Pointer wrap: fill/drain 10, then 12 words straddling the end of the array
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 8'(8'h30 + i));
            exp_std($sformatf("wrap_fill%0d", i), 5'(i + 1), 1'b0, 1'b0, 1'b0, 8'h00);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
            exp_std($sformatf("wrap_drain%0d", i), 5'(9 - i), 1'b0, 1'b0, 1'b1, 8'(8'h30 + i));
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 8'(8'hA0 + i));
            exp_std($sformatf("wrap_wr%0d", i), 5'(i + 1), 1'b0, 1'b0, 1'b0, 8'h39);
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
            exp_std($sformatf("wrap_rd%0d", i), 5'(11 - i), 1'b0, 1'b0, 1'b1, 8'(8'hA0 + i));
        end

        // Overflow: push+pop on a full FIFO drops 0x55 and still pops the head
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 8'(8'h10 + i));
            exp_std($sformatf("ovf_fill%0d", i), 5'(i + 1), 1'b0, 1'b0, 1'b0, 8'hAB);
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h55);
        exp_std("ovf_both", 5'd15, 1'b1, 1'b0, 1'b1, 8'h10);
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
            exp_std($sformatf("ovf_drain%0d", i), 5'(14 - i), 1'b1, 1'b0, 1'b1, 8'(8'h11 + i));
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        exp_std("udf_read", 5'd0, 1'b1, 1'b1, 1'b0, 8'h1F);

        // Mid-stream flush with a concurrent write clears everything, including sticky flags
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
            exp_std($sformatf("fl_fill%0d", i), 5'(i + 1), 1'b1, 1'b1, 1'b0, 8'h1F);
        end
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h47);
        exp_std("flush", 5'd0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        exp_std("flush_idle", 5'd0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Reset during a write burst with a valid pulse pending
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        exp_std("rst_pre_udf", 5'd0, 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 8'(8'h61 + i));
            exp_std($sformatf("rst_burst%0d", i), 5'(i + 1), 1'b0, 1'b1, 1'b0, 8'h00);
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h64);
        exp_std("rst_burst_rw", 5'd3, 1'b0, 1'b1, 1'b1, 8'h61);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h65);
        exp_std("rst_mid", 5'd0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h66);
        exp_std("rst_after_wr", 5'd1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        exp_std("rst_after_rd", 5'd0, 1'b0, 1'b0, 1'b1, 8'h66);

        // FWFT instance: write shows next cycle, pop acknowledges the shown word
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        exp_fw("fw_reset", 5'd0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h3C);
        exp_fw("fw_wr3c", 5'd1, 1'b1, 8'h3C);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        exp_fw("fw_pop3c", 5'd0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h11);
        exp_fw("fw_wr11", 5'd1, 1'b1, 8'h11);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h22);
        exp_fw("fw_wr22", 5'd2, 1'b1, 8'h11);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        exp_fw("fw_pop11", 5'd1, 1'b1, 8'h22);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        exp_fw("fw_pop22", 5'd0, 1'b0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
